opcode_encoder: RTL and testbench
=================================

// Module: opcode_encoder
// PURPOSE
//  Packs decoded instruction fields (opcode, encoding, variant, registers, immediate, operand size) into the
//  32-bit Skiron instruction word that OpcodeDecoder consumes. Inverse of the decoder.
//  Used by the debug/instruction-injection path and the self-test sequencer to build instructions in hardware.
//  Two-stage valid/ready pipeline with immediate range checking and saturating statistics counters.
// PARAMETERS
//  COUNTER_WIDTH   16   width of EncodedCount / ErrorCount
//  ZERO_ON_ERROR   1    1: OutWord forced to 32'h0 on error; 0: OutWord carries truncated packing
// PORTS
//  Clock          in   1    single clock, all state on posedge
//  Reset_n        in   1    asynchronous, active-low reset
//  InValid        in   1    request valid
//  InReady        out  1    request accepted when InValid && InReady
//  InOpcode       in   6    opcode
//  InEncoding     in   2    00=A 01=B 10=C 11=D
//  InVariant      in   2    variant
//  InRegister1    in   6    register1 (A,B,D)
//  InRegister2    in   6    register2 (A,D)
//  InRegister3    in   6    register3 (A)
//  InImmediate    in   32   two's-complement immediate (B: U16, C: S20, D: S8; ignored for A)
//  InOperandSize  in   2    operand size (A,C,D)
//  OutValid       out  1    encoded word valid
//  OutReady       in   1    consumer accepts when OutValid && OutReady
//  OutWord        out  32   encoded instruction
//  OutError       out  1    immediate out of range for selected encoding
//  EncodedCount   out  CW   good words delivered, saturating
//  ErrorCount     out  CW   error words delivered, saturating
// BEHAVIOUR
//  Word layout: b1=[31:24] b2=[23:16] b3=[15:8] b4=[7:0]; b1={InEncoding,InOpcode} for all encodings
//  A: b2={R1,Var} b3={R3[1:0],R2} b4={Size,2'b00,R3[5:2]}
//  B: b2={R1,Var} b3=Imm[7:0] b4=Imm[15:8]
//  C: b2={Imm[5:0],Var} b3=Imm[13:6] b4={Size,Imm[19:14]}; R1/R2 not encoded (immediate occupies those bits)
//  D: b2={R1,Var} b3={Imm[1:0],R2} b4={Size,Imm[7:2]}
//  Range rules: B 0..65535; C -524288..524287; D -128..127; A never errors. Out of range -> OutError=1
//  Stage 1 (S1): on accept, register range check + packed word. Stage 2 (S2): output register
//  Latency: accept at edge N -> OutValid high after edge N+1 (two registers; full throughput 1 word/cycle)
//  advance2 = !S2.valid || OutReady; advance1 = !S1.valid || advance2; InReady = advance1 (combinational)
//  Backpressure: OutValid/OutWord/OutError held stable while OutValid && !OutReady; no drop, no duplicate
//  Order preserved; requests never reordered or merged
//  Counters update on output handshake: OutError ? ErrorCount++ : EncodedCount++; stick at all-ones
//  Reset (async, any time incl. mid-transfer): S1/S2 valid=0, OutValid=0, OutWord=0, OutError=0,
//   counters=0; InReady=1 once Reset_n high; in-flight requests discarded
//  Simultaneous accept and output handshake in same cycle: both occur, pipeline occupancy unchanged
// TESTING
//  A: op=01 R1=1 R2=2 R3=3 Var=0 Size=2 -> OutWord=32'h0104C280, OutError=0, 2 cycles after accept
//  B: op=05 R1=5 Var=1 Imm=0xBEEF -> 32'h4515EFBE; Imm=65536 -> OutError=1, OutWord=0, ErrorCount=1
//  D: op=00 R1=0 R2=0 Size=0 Imm=-1 -> 32'hC000C03F; Imm=128 -> OutError=1; Imm=-128 -> no error
//  C: op=10 Var=0 Size=1 Imm=-524288 -> 32'h90000060; Imm=524288 -> OutError=1
//  Backpressure: 4 back-to-back requests, OutReady=0 for 5 cycles -> InReady low after 2 captured,
//   all 4 words emitted in order once OutReady=1, EncodedCount=4
//  Reset: drop Reset_n with S1 and S2 full -> OutValid=0 and counters=0 immediately; next request encodes normally

Source files
------------

// File: rtl/opcode_encoder.sv
// Packs decoded Skiron instruction fields into a 32-bit instruction word (inverse of OpcodeDecoder).
// Two-stage valid/ready pipeline with immediate range checking and saturating delivery counters.
module opcode_encoder #(
    parameter int unsigned COUNTER_WIDTH = 16,
    parameter bit          ZERO_ON_ERROR = 1'b1
) (
    input  logic                     Clock,
    input  logic                     Reset_n,
    input  logic                     InValid,
    output logic                     InReady,
    input  logic [5:0]               InOpcode,
    input  logic [1:0]               InEncoding,
    input  logic [1:0]               InVariant,
    input  logic [5:0]               InRegister1,
    input  logic [5:0]               InRegister2,
    input  logic [5:0]               InRegister3,
    input  logic [31:0]              InImmediate,
    input  logic [1:0]               InOperandSize,
    output logic                     OutValid,
    input  logic                     OutReady,
    output logic [31:0]              OutWord,
    output logic                     OutError,
    output logic [COUNTER_WIDTH-1:0] EncodedCount,
    output logic [COUNTER_WIDTH-1:0] ErrorCount
);

    localparam logic [COUNTER_WIDTH-1:0] CntOne = COUNTER_WIDTH'(1);

    logic [7:0]  b1, b2, b3, b4;
    logic        imm_err;
    logic [31:0] packed_word;

    logic        s1_valid_q, s1_valid_d;
    logic [31:0] s1_word_q, s1_word_d;
    logic        s1_err_q, s1_err_d;
    logic        s2_valid_q, s2_valid_d;
    logic [31:0] s2_word_q, s2_word_d;
    logic        s2_err_q, s2_err_d;
    logic [COUNTER_WIDTH-1:0] enc_cnt_q, enc_cnt_d;
    logic [COUNTER_WIDTH-1:0] err_cnt_q, err_cnt_d;

    logic advance1, advance2, out_hs;

    always_comb begin
        b1      = {InEncoding, InOpcode};
        b2      = {InRegister1, InVariant};
        b3      = 8'h00;
        b4      = 8'h00;
        imm_err = 1'b0;
        unique case (InEncoding)
            2'b00: begin
                b3 = {InRegister3[1:0], InRegister2};
                b4 = {InOperandSize, 2'b00, InRegister3[5:2]};
            end
            2'b01: begin
                b3      = InImmediate[7:0];
                b4      = InImmediate[15:8];
                imm_err = |InImmediate[31:16];
            end
            2'b10: begin
                // Immediate takes over the register1 field in this encoding.
                b2      = {InImmediate[5:0], InVariant};
                b3      = InImmediate[13:6];
                b4      = {InOperandSize, InImmediate[19:14]};
                imm_err = !((&InImmediate[31:19]) || (~|InImmediate[31:19]));
            end
            2'b11: begin
                b3      = {InImmediate[1:0], InRegister2};
                b4      = {InOperandSize, InImmediate[7:2]};
                imm_err = !((&InImmediate[31:7]) || (~|InImmediate[31:7]));
            end
        endcase
        packed_word = {b1, b2, b3, b4};
        if (imm_err && ZERO_ON_ERROR) begin
            packed_word = 32'h0;
        end
    end

    assign advance2 = !s2_valid_q || OutReady;
    assign advance1 = !s1_valid_q || advance2;
    assign InReady  = advance1;
    assign out_hs   = s2_valid_q && OutReady;

    always_comb begin
        s1_valid_d = s1_valid_q;
        s1_word_d  = s1_word_q;
        s1_err_d   = s1_err_q;
        s2_valid_d = s2_valid_q;
        s2_word_d  = s2_word_q;
        s2_err_d   = s2_err_q;
        enc_cnt_d  = enc_cnt_q;
        err_cnt_d  = err_cnt_q;

        if (advance1) begin
            s1_valid_d = InValid;
            if (InValid) begin
                s1_word_d = packed_word;
                s1_err_d  = imm_err;
            end
        end

        if (advance2) begin
            s2_valid_d = s1_valid_q;
            if (s1_valid_q) begin
                s2_word_d = s1_word_q;
                s2_err_d  = s1_err_q;
            end
        end

        if (out_hs) begin
            if (s2_err_q) begin
                if (!(&err_cnt_q)) err_cnt_d = err_cnt_q + CntOne;
            end else begin
                if (!(&enc_cnt_q)) enc_cnt_d = enc_cnt_q + CntOne;
            end
        end
    end

    always_ff @(posedge Clock or negedge Reset_n) begin
        if (!Reset_n) begin
            s1_valid_q <= 1'b0;
            s1_word_q  <= 32'h0;
            s1_err_q   <= 1'b0;
            s2_valid_q <= 1'b0;
            s2_word_q  <= 32'h0;
            s2_err_q   <= 1'b0;
            enc_cnt_q  <= '0;
            err_cnt_q  <= '0;
        end else begin
            s1_valid_q <= s1_valid_d;
            s1_word_q  <= s1_word_d;
            s1_err_q   <= s1_err_d;
            s2_valid_q <= s2_valid_d;
            s2_word_q  <= s2_word_d;
            s2_err_q   <= s2_err_d;
            enc_cnt_q  <= enc_cnt_d;
            err_cnt_q  <= err_cnt_d;
        end
    end

    assign OutValid     = s2_valid_q;
    assign OutWord      = s2_word_q;
    assign OutError     = s2_err_q;
    assign EncodedCount = enc_cnt_q;
    assign ErrorCount   = err_cnt_q;

endmodule

// File: tb/tb_opcode_encoder.sv
// Bench for opcode_encoder: directed vectors plus randomized traffic checked against an
// arithmetic reference model and an in-flight queue.
module tb_opcode_encoder;

    localparam int unsigned CW     = 4;
    localparam int          CntMax = (1 << CW) - 1;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          in_valid, in_ready;
    logic [5:0]    in_opcode;
    logic [1:0]    in_encoding, in_variant;
    logic [5:0]    in_r1, in_r2, in_r3;
    logic [31:0]   in_imm;
    logic [1:0]    in_size;
    logic          out_valid, out_ready, out_error;
    logic [31:0]   out_word;
    logic [CW-1:0] enc_cnt, err_cnt;

    always #5 clk = ~clk;

    opcode_encoder #(
        .COUNTER_WIDTH(CW),
        .ZERO_ON_ERROR(1'b1)
    ) dut (
        .Clock        (clk),
        .Reset_n      (rst_n),
        .InValid      (in_valid),
        .InReady      (in_ready),
        .InOpcode     (in_opcode),
        .InEncoding   (in_encoding),
        .InVariant    (in_variant),
        .InRegister1  (in_r1),
        .InRegister2  (in_r2),
        .InRegister3  (in_r3),
        .InImmediate  (in_imm),
        .InOperandSize(in_size),
        .OutValid     (out_valid),
        .OutReady     (out_ready),
        .OutWord      (out_word),
        .OutError     (out_error),
        .EncodedCount (enc_cnt),
        .ErrorCount   (err_cnt)
    );

    typedef struct {
        logic [31:0] word;
        logic        err;
        int          acc_edge;
    } exp_t;

    exp_t        q[$];
    int          n_checks = 0;
    int          n_err    = 0;
    int          ecount   = 0;
    int          enc_m    = 0;
    int          err_m    = 0;
    bit          last_acc;
    logic [31:0] bnd [12] = '{32'd0, 32'd127, 32'd128, -32'sd128, -32'sd129, 32'd65535,
                              32'd65536, 32'd524287, 32'd524288, -32'sd524288, -32'sd524289,
                              -32'sd1};

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Field layout computed with plain base-256 / base-4 arithmetic on field values.
    function automatic logic [32:0] ref_encode(input logic [1:0] enc, input logic [5:0] op,
                                               input logic [1:0] vr, input logic [5:0] ra,
                                               input logic [5:0] rb, input logic [5:0] rc,
                                               input logic [31:0] imm, input logic [1:0] sz);
        int          si;
        int unsigned e, o, v, r1, r2, r3, s, ui, u, b1, b2, b3, b4, w;
        bit          err;
        si = imm;  ui = imm;
        e  = enc;  o  = op;  v = vr;  r1 = ra;  r2 = rb;  r3 = rc;  s = sz;
        b1 = e * 64 + o;
        case (e)
            0: begin
                err = 0;
                b2 = r1 * 4 + v;  b3 = (r3 % 4) * 64 + r2;  b4 = s * 64 + r3 / 4;
            end
            1: begin
                err = (si < 0) || (si > 65535);
                u  = ui % 65536;
                b2 = r1 * 4 + v;  b3 = u % 256;  b4 = u / 256;
            end
            2: begin
                err = (si < -524288) || (si > 524287);
                u  = ui % 1048576;
                b2 = (u % 64) * 4 + v;  b3 = (u / 64) % 256;  b4 = s * 64 + u / 16384;
            end
            default: begin
                err = (si < -128) || (si > 127);
                u  = ui % 256;
                b2 = r1 * 4 + v;  b3 = (u % 4) * 64 + r2;  b4 = s * 64 + u / 4;
            end
        endcase
        w = b1 * 16777216 + b2 * 65536 + b3 * 256 + b4;
        if (err) w = 0;
        return {err, w};
    endfunction

    // Called just after a negedge with inputs driven; returns at the next negedge.
    task automatic tick();
        bit          exp_ready, exp_valid;
        exp_t        e;
        logic [32:0] r;
        #1;
        exp_ready = (q.size() < 2) || out_ready;
        exp_valid = (q.size() > 0) && (ecount >= q[0].acc_edge + 1);
        chk("in_ready", in_ready, exp_ready);
        chk("out_valid", out_valid, exp_valid);
        if (exp_valid) begin
            chk("out_word", out_word, q[0].word);
            chk("out_error", out_error, q[0].err);
        end
        last_acc = in_valid && exp_ready;
        if (exp_valid && out_ready) begin
            e = q.pop_front();
            if (e.err) begin
                if (err_m < CntMax) err_m++;
            end else begin
                if (enc_m < CntMax) enc_m++;
            end
        end
        if (last_acc) begin
            r = ref_encode(in_encoding, in_opcode, in_variant, in_r1, in_r2, in_r3, in_imm,
                           in_size);
            e.word = r[31:0];
            e.err = r[32];
            e.acc_edge = ecount + 1;
            q.push_back(e);
        end
        @(posedge clk);
        ecount++;
        #1;
        chk("encoded_count", enc_cnt, enc_m);
        chk("error_count", err_cnt, err_m);
        @(negedge clk);
    endtask

    task automatic set_req(input logic [1:0] enc, input logic [5:0] op, input logic [1:0] vr,
                           input logic [5:0] ra, input logic [5:0] rb, input logic [5:0] rc,
                           input logic [31:0] imm, input logic [1:0] sz);
        in_encoding = enc;  in_opcode = op;  in_variant = vr;
        in_r1 = ra;  in_r2 = rb;  in_r3 = rc;  in_imm = imm;  in_size = sz;
        in_valid = 1'b1;
    endtask

    task automatic rand_req();
        logic [31:0] imm;
        case ($urandom_range(0, 5))
            0:       imm = $urandom;
            1:       imm = $urandom_range(0, 65535);
            2:       imm = 32'd0 - $urandom_range(0, 600000);
            3:       imm = bnd[$urandom_range(0, 11)];
            4:       imm = $urandom_range(0, 300) - 150;
            default: imm = $urandom_range(0, 1100000) - 550000;
        endcase
        set_req(2'($urandom), 6'($urandom), 2'($urandom), 6'($urandom), 6'($urandom),
                6'($urandom), imm, 2'($urandom));
    endtask

    task automatic do_reset();
        in_valid = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_word", out_word, 0);
        chk("rst_out_error", out_error, 0);
        chk("rst_encoded_count", enc_cnt, 0);
        chk("rst_error_count", err_cnt, 0);
        q.delete();
        enc_m = 0;
        err_m = 0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic directed(input string tag, input logic [1:0] enc, input logic [5:0] op,
                            input logic [1:0] vr, input logic [5:0] ra, input logic [5:0] rb,
                            input logic [5:0] rc, input logic [31:0] imm, input logic [1:0] sz,
                            input logic [31:0] exp_word, input logic exp_err);
        int waited;
        set_req(enc, op, vr, ra, rb, rc, imm, sz);
        out_ready = 1'b1;
        tick();
        in_valid = 1'b0;
        waited = 0;
        while (!out_valid && waited < 6) begin
            tick();
            waited++;
        end
        chk({tag, "_valid"}, out_valid, 1);
        chk({tag, "_latency"}, waited, 1);
        chk({tag, "_word"}, out_word, exp_word);
        chk({tag, "_err"}, out_error, exp_err);
        tick();
    endtask

    initial begin
        int k;
        rst_n = 1'b1;  in_valid = 1'b0;  out_ready = 1'b0;
        set_req(2'd0, 6'd0, 2'd0, 6'd0, 6'd0, 6'd0, 32'd0, 2'd0);
        in_valid = 1'b0;
        @(negedge clk);
        do_reset();

        directed("A",      2'd0, 6'h01, 2'd0, 6'd1, 6'd2, 6'd3, 32'd0,        2'd2, 32'h0104C280, 1'b0);
        directed("B",      2'd1, 6'h05, 2'd1, 6'd5, 6'd0, 6'd0, 32'h0000BEEF, 2'd0, 32'h4515EFBE, 1'b0);
        directed("B_ovf",  2'd1, 6'h05, 2'd1, 6'd5, 6'd0, 6'd0, 32'd65536,    2'd0, 32'h0,        1'b1);
        chk("B_ovf_error_count", err_cnt, 1);
        directed("D",      2'd3, 6'h00, 2'd0, 6'd0, 6'd0, 6'd0, 32'hFFFFFFFF, 2'd0, 32'hC000C03F, 1'b0);
        directed("D_ovf",  2'd3, 6'h00, 2'd0, 6'd0, 6'd0, 6'd0, 32'd128,      2'd0, 32'h0,        1'b1);
        directed("D_min",  2'd3, 6'h00, 2'd0, 6'd0, 6'd0, 6'd0, 32'hFFFFFF80, 2'd0, 32'hC0000020, 1'b0);
        directed("C",      2'd2, 6'h10, 2'd0, 6'd0, 6'd0, 6'd0, 32'hFFF80000, 2'd1, 32'h90000060, 1'b0);
        directed("C_ovf",  2'd2, 6'h10, 2'd0, 6'd0, 6'd0, 6'd0, 32'd524288,   2'd1, 32'h0,        1'b1);

        // Four back-to-back requests against a stalled consumer.
        do_reset();
        out_ready = 1'b0;
        k = 0;
        for (int c = 0; c < 5; c++) begin
            if (k < 4) begin
                set_req(2'd0, 6'($urandom), 2'($urandom), 6'($urandom), 6'($urandom),
                        6'($urandom), $urandom, 2'($urandom));
            end else begin
                in_valid = 1'b0;
            end
            tick();
            if (last_acc) k++;
        end
        #1 chk("bp_in_ready_low", in_ready, 0);
        out_ready = 1'b1;
        for (int c = 0; c < 20 && (k < 4 || q.size() > 0); c++) begin
            if (k < 4) begin
                set_req(2'd0, 6'($urandom), 2'($urandom), 6'($urandom), 6'($urandom),
                        6'($urandom), $urandom, 2'($urandom));
            end else begin
                in_valid = 1'b0;
            end
            tick();
            if (last_acc) k++;
        end
        in_valid = 1'b0;
        chk("bp_encoded_count", enc_cnt, 4);

        // Reset with both stages occupied.
        out_ready = 1'b0;
        for (int c = 0; c < 2; c++) begin
            set_req(2'd1, 6'h05, 2'd1, 6'd5, 6'd0, 6'd0, 32'h1234, 2'd0);
            tick();
        end
        in_valid = 1'b0;
        chk("pre_rst_out_valid", out_valid, 1);
        do_reset();
        #1 chk("post_rst_in_ready", in_ready, 1);
        directed("post_rst", 2'd0, 6'h01, 2'd0, 6'd1, 6'd2, 6'd3, 32'd0, 2'd2, 32'h0104C280, 1'b0);
        chk("post_rst_encoded_count", enc_cnt, 1);

        // Random traffic with random backpressure; counters saturate at CntMax.
        for (int c = 0; c < 400; c++) begin
            rand_req();
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 3) != 0);
            tick();
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        for (int c = 0; c < 6; c++) tick();
        chk("drain_empty", out_valid, 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
